// File: rtl/sms_card_rst_seq.sv
// Multi-channel staged reset sequencer for the SMS card simulation (core, memory, I/O, typewriter groups).
// Define SMS_RST_SEQ_DEBOUNCE_EN to qualify man_rst_n over DEBOUNCE_CYCLES consecutive low samples.
module sms_card_rst_seq #(
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int STAGE_GAP   = 100,
  parameter int CNT_W       = 16
`ifdef SMS_RST_SEQ_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = 8
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pwr_good,
  input  logic                man_rst_n,
  output logic [CHANNELS-1:0] rst_a,
  output logic [CHANNELS-1:0] rst_b,
  output logic                seq_done,
  output logic                busy
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CHANNELS - 1);
  localparam bit ALL_AT_ONCE = (CHANNELS == 1) || (STAGE_GAP == 0);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_STAGE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_stateNxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cntNxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idxNxt;
  logic [CHANNELS-1:0] r_rstA;
  logic [CHANNELS-1:0] w_rstANxt;
  logic                r_done;
  logic                w_doneNxt;
  logic                r_busy;
  logic                w_busyNxt;
  logic                w_manReq;
  logic                w_fault;

`ifdef SMS_RST_SEQ_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_FULL = DB_W'(DEBOUNCE_CYCLES);

  logic [DB_W-1:0] r_dbCnt;

  // Saturating run-length of consecutive low samples; any high sample drops the request at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dbCnt <= '0;
    end else if (man_rst_n) begin
      r_dbCnt <= '0;
    end else if (r_dbCnt != DB_FULL) begin
      r_dbCnt <= r_dbCnt + 1'b1;
    end
  end

  assign w_manReq = !man_rst_n && (r_dbCnt == DB_FULL);
`else
  assign w_manReq = !man_rst_n;
`endif

  assign w_fault = !pwr_good || w_manReq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rstA  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_stateNxt;
      r_cnt   <= w_cntNxt;
      r_idx   <= w_idxNxt;
      r_rstA  <= w_rstANxt;
      r_done  <= w_doneNxt;
      r_busy  <= w_busyNxt;
    end
  end

  // Fault is checked first so it overrides any release scheduled for the same edge.
  always_comb begin
    w_stateNxt = r_state;
    w_cntNxt   = r_cnt;
    w_idxNxt   = r_idx;
    w_rstANxt  = r_rstA;
    w_doneNxt  = r_done;

    if (w_fault) begin
      w_stateNxt = ST_HOLD;
      w_cntNxt   = '0;
      w_idxNxt   = '0;
      w_rstANxt  = '0;
      w_doneNxt  = 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_cntNxt = '0;
            if (ALL_AT_ONCE) begin
              w_rstANxt  = '1;
              w_doneNxt  = 1'b1;
              w_stateNxt = ST_RUN;
            end else begin
              w_rstANxt[0] = 1'b1;
              w_idxNxt     = IDX_W'(1);
              w_stateNxt   = ST_STAGE;
            end
          end else begin
            w_cntNxt = r_cnt + 1'b1;
          end
        end
        ST_STAGE: begin
          if (r_cnt == GAP_LAST) begin
            w_cntNxt         = '0;
            w_rstANxt[r_idx] = 1'b1;
            if (r_idx == LAST_IDX) begin
              w_stateNxt = ST_RUN;
              w_doneNxt  = 1'b1;
            end else begin
              w_idxNxt = r_idx + 1'b1;
            end
          end else begin
            w_cntNxt = r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          w_rstANxt = '1;
          w_doneNxt = 1'b1;
        end
        default: begin
          w_stateNxt = ST_HOLD;
          w_cntNxt   = '0;
          w_idxNxt   = '0;
          w_rstANxt  = '0;
          w_doneNxt  = 1'b0;
        end
      endcase
    end

    w_busyNxt = (w_stateNxt != ST_RUN);
  end

  assign rst_a    = r_rstA;
  assign rst_b    = ~r_rstA;
  assign seq_done = r_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_sms_card_rst_seq.sv
// Self-checking bench for sms_card_rst_seq: default-parameter instance plus a STAGE_GAP=0 instance.
// Vector tables and hand sequences push expectations into a scoreboard queue that is popped at each check.
module tb_sms_card_rst_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pwr_good;
  logic       man_rst_n;
  logic [3:0] rst_a;
  logic [3:0] rst_b;
  logic       seq_done;
  logic       busy;

  logic       reset2N;
  logic       pwrGood2 = 1'b1;
  logic       manRstN2 = 1'b1;
  logic [3:0] rstA2;
  logic [3:0] rstB2;
  logic       seqDone2;
  logic       busy2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sms_card_rst_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pwr_good  (pwr_good),
    .man_rst_n (man_rst_n),
    .rst_a     (rst_a),
    .rst_b     (rst_b),
    .seq_done  (seq_done),
    .busy      (busy)
  );

  sms_card_rst_seq #(
    .CHANNELS    (4),
    .HOLD_CYCLES (5),
    .STAGE_GAP   (0),
    .CNT_W       (16)
  ) dutGap0 (
    .clk       (clk),
    .reset_n   (reset2N),
    .pwr_good  (pwrGood2),
    .man_rst_n (manRstN2),
    .rst_a     (rstA2),
    .rst_b     (rstB2),
    .seq_done  (seqDone2),
    .busy      (busy2)
  );

  typedef struct {
    logic       pwrGood;
    logic       manRstN;
    int         edges;
    logic [3:0] expRstA;
    logic       expDone;
    logic       expBusy;
  } vec_t;

  typedef struct {
    logic [3:0] rstA;
    logic       done;
    logic       busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sbQ[$];

  // Invariants checked every cycle on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (rst_b !== ~rst_a) begin
      miscompares++;
      $display("[TB] FAIL rst_b_inverse: rst_a=%b rst_b=%b", rst_a, rst_b);
    end
    if (seq_done !== (&rst_a)) begin
      miscompares++;
      $display("[TB] FAIL seq_done_vs_rst_a: seq_done=%b rst_a=%b", seq_done, rst_a);
    end
    if (busy !== ~seq_done) begin
      miscompares++;
      $display("[TB] FAIL busy_vs_done: busy=%b seq_done=%b", busy, seq_done);
    end
    for (int k = 1; k < 4; k++) begin
      if (rst_a[k] && !rst_a[k-1]) begin
        miscompares++;
        $display("[TB] FAIL release_order: rst_a=%b", rst_a);
      end
    end
    if (rstB2 !== ~rstA2) begin
      miscompares++;
      $display("[TB] FAIL gap0_rst_b_inverse: rst_a=%b rst_b=%b", rstA2, rstB2);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic pg, input logic mn, input int edges,
                        input logic [3:0] rstA, input logic done, input logic bsy);
    vec_t v;
    v.pwrGood = pg;
    v.manRstN = mn;
    v.edges   = edges;
    v.expRstA = rstA;
    v.expDone = done;
    v.expBusy = bsy;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    pwr_good  = v.pwrGood;
    man_rst_n = v.manRstN;
    e.rstA = v.expRstA;
    e.done = v.expDone;
    e.busy = v.expBusy;
    sbQ.push_back(e);
    tick(v.edges);
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    vectors++;
    if (sbQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: scoreboard empty, rst_a=%b", name, rst_a);
      return;
    end
    e = sbQ.pop_front();
    if (rst_a !== e.rstA || rst_b !== ~e.rstA || seq_done !== e.done || busy !== e.busy) begin
      miscompares++;
      $display("[TB] FAIL %s: got rst_a=%b rst_b=%b seq_done=%b busy=%b, want rst_a=%b rst_b=%b seq_done=%b busy=%b",
               name, rst_a, rst_b, seq_done, busy, e.rstA, ~e.rstA, e.done, e.busy);
    end
  endtask

  task automatic expectNow(input string name, input logic [3:0] rstA, input logic done, input logic bsy);
    exp_t e;
    e.rstA = rstA;
    e.done = done;
    e.busy = bsy;
    sbQ.push_back(e);
    checkOutput(name);
  endtask

  task automatic runVecs(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("%s[%0d]", name, i));
    end
    vecs.delete();
  endtask

  // Leaves reset_n high just after a rising edge, so the next edge is edge 1.
  task automatic doReset();
    reset_n   = 1'b0;
    pwr_good  = 1'b1;
    man_rst_n = 1'b1;
    tick(2);
    expectNow("reset_state", 4'b0000, 1'b0, 1'b1);
    reset_n = 1'b1;
  endtask

  task automatic addFullSequence();
    addVec(1, 1, 999, 4'b0000, 0, 1);
    addVec(1, 1,   1, 4'b0001, 0, 1);
    addVec(1, 1,  99, 4'b0001, 0, 1);
    addVec(1, 1,   1, 4'b0011, 0, 1);
    addVec(1, 1,  99, 4'b0011, 0, 1);
    addVec(1, 1,   1, 4'b0111, 0, 1);
    addVec(1, 1,  99, 4'b0111, 0, 1);
    addVec(1, 1,   1, 4'b1111, 1, 0);
    addVec(1, 1,  50, 4'b1111, 1, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    reset2N   = 1'b0;
    pwr_good  = 1'b1;
    man_rst_n = 1'b1;
    tick(2);
    expectNow("reset_state_initial", 4'b0000, 1'b0, 1'b1);

    // STAGE_GAP=0 instance: all channels together at edge 5, main instance still held in reset.
    reset2N = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      logic [3:0] want;
      tick(1);
      want = (e >= 5) ? 4'b1111 : 4'b0000;
      vectors++;
      if (rstA2 !== want || seqDone2 !== (e >= 5) || busy2 !== (e < 5)) begin
        miscompares++;
        $display("[TB] FAIL gap0_edge%0d: got rst_a=%b seq_done=%b busy=%b, want rst_a=%b seq_done=%b busy=%b",
                 e, rstA2, seqDone2, busy2, want, (e >= 5), (e < 5));
      end
    end
    expectNow("reset_held_while_clocked", 4'b0000, 1'b0, 1'b1);

    // Clean power-up sequence.
    reset_n = 1'b1;
    addFullSequence();
    runVecs("powerup");

    // One-cycle power loss after channels 0 and 1 are out, then a full restart.
    doReset();
    addVec(1, 1, 1000, 4'b0001, 0, 1);
    addVec(1, 1,  100, 4'b0011, 0, 1);
    addVec(1, 1,   49, 4'b0011, 0, 1);
    addVec(0, 1,    1, 4'b0000, 0, 1);
    addVec(1, 1,  999, 4'b0000, 0, 1);
    addVec(1, 1,    1, 4'b0001, 0, 1);
    addVec(1, 1,  100, 4'b0011, 0, 1);
    runVecs("pwrfail_mid");

    // Power loss exactly on the edge scheduled to release channel 1.
    doReset();
    addVec(1, 1, 1000, 4'b0001, 0, 1);
    addVec(1, 1,   99, 4'b0001, 0, 1);
    addVec(0, 1,    1, 4'b0000, 0, 1);
    addVec(1, 1,  999, 4'b0000, 0, 1);
    addVec(1, 1,    1, 4'b0001, 0, 1);
    runVecs("fault_on_release");

    // reset_n pulsed mid-STAGE must clear outputs without a clock edge.
    doReset();
    addVec(1, 1, 1000, 4'b0001, 0, 1);
    addVec(1, 1,  150, 4'b0011, 0, 1);
    runVecs("pre_async");
    #1;
    reset_n = 1'b0;
    #1;
    expectNow("async_reset_immediate", 4'b0000, 1'b0, 1'b1);
    tick(1);
    expectNow("async_reset_held", 4'b0000, 1'b0, 1'b1);
    reset_n = 1'b1;
    addFullSequence();
    runVecs("after_async");

    // Manual reset request while in RUN.
`ifdef SMS_RST_SEQ_DEBOUNCE_EN
    addVec(1, 0, 7, 4'b1111, 1, 0);
    addVec(1, 1, 1, 4'b1111, 1, 0);
    addVec(1, 0, 8, 4'b1111, 1, 0);
    addVec(1, 0, 1, 4'b0000, 0, 1);
`else
    addVec(1, 0, 1, 4'b0000, 0, 1);
`endif
    addVec(1, 1, 999, 4'b0000, 0, 1);
    addVec(1, 1,   1, 4'b0001, 0, 1);
    runVecs("manual");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
